// File: rtl/reg_writeback_ctrl.sv
// Register-file write-side controller: arbitrates ALU/load writes into a FIFO and retires one per cycle.
// Optional macro WB_FORWARD_EN adds per-read-port forwarding of the youngest pending write.
module reg_writeback_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [ADDR_W-1:0]            alu_addr,
  input  logic [DATA_W-1:0]            alu_data,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [ADDR_W-1:0]            mem_addr,
  input  logic [DATA_W-1:0]            mem_data,
  output logic                         wb_we,
  output logic [ADDR_W-1:0]            wb_addr,
  output logic [DATA_W-1:0]            wb_data,
  input  logic [ADDR_W-1:0]            rd_addr1,
  input  logic [ADDR_W-1:0]            rd_addr2,
  output logic                         hazard1,
  output logic                         hazard2,
`ifdef WB_FORWARD_EN
  output logic                         fwd_hit1,
  output logic                         fwd_hit2,
  output logic [DATA_W-1:0]            fwd_data1,
  output logic [DATA_W-1:0]            fwd_data2,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   pending_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic              space, mem_acc, alu_acc, push, pop;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic [DEPTH-1:0]  occupied;

  // Space is judged on the pre-pop count, so a full queue stalls even while draining.
  assign space     = count < CNT_W'(DEPTH);
  assign mem_ready = space;
  assign alu_ready = space & ~mem_valid;
  assign mem_acc   = mem_valid & space;
  assign alu_acc   = alu_valid & alu_ready;
  assign in_addr   = mem_acc ? mem_addr : alu_addr;
  assign in_data   = mem_acc ? mem_data : alu_data;
  // Writes to r0 complete the handshake but never occupy a slot.
  assign push      = (mem_acc | alu_acc) & (in_addr != '0);
  assign pop       = count != '0;
  assign pending_count = count;

  always_comb begin
    occupied = '0;
    for (int i = 0; i < DEPTH; i++)
      occupied[i] = CNT_W'(PTR_W'(PTR_W'(i) - head)) < count;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      if (pop) begin
        wb_we   <= 1'b1;
        wb_addr <= q_addr[head];
        wb_data <= q_data[head];
        head    <= head + PTR_W'(1);
      end else begin
        wb_we   <= 1'b0;
      end
      if (push)
        tail <= tail + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail] <= in_addr;
      q_data[tail] <= in_data;
    end
  end

  always_comb begin
    hazard1 = wb_we && (wb_addr == rd_addr1);
    hazard2 = wb_we && (wb_addr == rd_addr2);
    for (int i = 0; i < DEPTH; i++) begin
      if (occupied[i] && (q_addr[i] == rd_addr1)) hazard1 = 1'b1;
      if (occupied[i] && (q_addr[i] == rd_addr2)) hazard2 = 1'b1;
    end
    if (rd_addr1 == '0) hazard1 = 1'b0;
    if (rd_addr2 == '0) hazard2 = 1'b0;
  end

`ifdef WB_FORWARD_EN
  logic [PTR_W-1:0] fidx;

  assign fwd_hit1 = hazard1;
  assign fwd_hit2 = hazard2;

  // Walk oldest to youngest so the last match (tail-most) wins; wb stage is older than any entry.
  always_comb begin
    fidx      = '0;
    fwd_data1 = (wb_we && (wb_addr == rd_addr1)) ? wb_data : '0;
    fwd_data2 = (wb_we && (wb_addr == rd_addr2)) ? wb_data : '0;
    for (int k = 0; k < DEPTH; k++) begin
      fidx = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (q_addr[fidx] == rd_addr1)) fwd_data1 = q_data[fidx];
      if ((CNT_W'(k) < count) && (q_addr[fidx] == rd_addr2)) fwd_data2 = q_data[fidx];
    end
    if (rd_addr1 == '0) fwd_data1 = '0;
    if (rd_addr2 == '0) fwd_data2 = '0;
  end
`endif

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Bench for reg_writeback_ctrl: directed scenarios plus random traffic against a queue-based reference.
module tb_reg_writeback_ctrl;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              alu_valid, mem_valid;
  logic              alu_ready, mem_ready;
  logic [ADDR_W-1:0] alu_addr, mem_addr, rd_addr1, rd_addr2, wb_addr;
  logic [DATA_W-1:0] alu_data, mem_data, wb_data;
  logic              wb_we, hazard1, hazard2;
  logic [CNT_W-1:0]  pending_count;
`ifdef WB_FORWARD_EN
  logic              fwd_hit1, fwd_hit2;
  logic [DATA_W-1:0] fwd_data1, fwd_data2;
`endif

  reg_writeback_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .hazard1(hazard1), .hazard2(hazard2),
`ifdef WB_FORWARD_EN
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
`endif
    .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t               mq[$];
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  bit                last_alu_acc, last_mem_acc;
  int                total = 0;
  int                bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_hz(input logic [ADDR_W-1:0] rd);
    if (rd == 0) return 1'b0;
    if (m_we && m_addr == rd) return 1'b1;
    foreach (mq[i]) if (mq[i].a == rd) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DATA_W-1:0] exp_fwd(input logic [ADDR_W-1:0] rd);
    logic [DATA_W-1:0] r = '0;
    if (rd == 0) return '0;
    if (m_we && m_addr == rd) r = m_data;
    foreach (mq[i]) if (mq[i].a == rd) r = mq[i].d;
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_we = 1'b0;
    m_addr = '0;
    m_data = '0;
    last_alu_acc = 1'b0;
    last_mem_acc = 1'b0;
  endtask

  task automatic model_edge();
    bit space;
    wr_t w;
    if (rst) begin
      model_reset();
      return;
    end
    space = mq.size() < DEPTH;
    last_mem_acc = mem_valid && space;
    last_alu_acc = alu_valid && space && !mem_valid;
    if (mq.size() > 0) begin
      w = mq.pop_front();
      m_we = 1'b1;
      m_addr = w.a;
      m_data = w.d;
    end else begin
      m_we = 1'b0;
    end
    if (last_mem_acc && mem_addr != 0) mq.push_back({mem_addr, mem_data});
    else if (last_alu_acc && alu_addr != 0) mq.push_back({alu_addr, alu_data});
  endtask

  task automatic check_all();
    bit space;
    space = mq.size() < DEPTH;
    chk("mem_ready", mem_ready, space);
    chk("alu_ready", alu_ready, space && !mem_valid);
    chk("pending_count", pending_count, mq.size());
    chk("wb_we", wb_we, m_we);
    chk("wb_addr", wb_addr, m_addr);
    chk("wb_data", wb_data, m_data);
    chk("hazard1", hazard1, exp_hz(rd_addr1));
    chk("hazard2", hazard2, exp_hz(rd_addr2));
`ifdef WB_FORWARD_EN
    chk("fwd_hit1", fwd_hit1, exp_hz(rd_addr1));
    chk("fwd_hit2", fwd_hit2, exp_hz(rd_addr2));
    chk("fwd_data1", fwd_data1, exp_fwd(rd_addr1));
    chk("fwd_data2", fwd_data2, exp_fwd(rd_addr2));
`endif
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic alu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n = 0;
    alu_valid = 1'b1;
    alu_addr = a;
    alu_data = d;
    do begin
      step();
      n++;
    end while (!last_alu_acc && n < 20);
    chk("alu_accept_timeout", last_alu_acc, 1);
    alu_valid = 1'b0;
  endtask

  initial begin
    bit a_hold = 0;
    bit m_hold = 0;
    alu_valid = 0; mem_valid = 0;
    alu_addr = 0; alu_data = 0; mem_addr = 0; mem_data = 0;
    rd_addr1 = 0; rd_addr2 = 0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wb_we", wb_we, 0);
    chk("rst_pending", pending_count, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // single write
    alu_valid = 1; alu_addr = 5; alu_data = 32'hDEAD_BEEF;
    #1 chk("single_ready", alu_ready, 1);
    step();
    alu_valid = 0;
    step();
    #1;
    chk("single_we", wb_we, 1);
    chk("single_addr", wb_addr, 5);
    chk("single_data", wb_data, 32'hDEAD_BEEF);
    step();
    chk("single_we_drop", wb_we, 0);

    // priority: mem wins over alu
    alu_valid = 1; alu_addr = 3; alu_data = 32'h11;
    mem_valid = 1; mem_addr = 4; mem_data = 32'h22;
    #1;
    chk("prio_alu_ready", alu_ready, 0);
    chk("prio_mem_ready", mem_ready, 1);
    step();
    mem_valid = 0;
    step();
    alu_valid = 0;
    #1;
    chk("prio_first_addr", wb_addr, 4);
    chk("prio_first_data", wb_data, 32'h22);
    step();
    chk("prio_second_addr", wb_addr, 3);
    chk("prio_second_data", wb_data, 32'h11);
    repeat (2) step();

    // back-to-back writes r1..r5
    for (int i = 1; i <= 5; i++) alu_write(ADDR_W'(i), 32'h100 + i);
    repeat (3) step();

    // r0 discard
    mem_valid = 1; mem_addr = 0; mem_data = 32'hFF; rd_addr1 = 0;
    #1 chk("r0_ready", mem_ready, 1);
    step();
    mem_valid = 0;
    #1;
    chk("r0_pending", pending_count, 0);
    chk("r0_hazard1", hazard1, 0);
    step();
    chk("r0_wb_we", wb_we, 0);

    // hazard on repeated destination
    rd_addr1 = 7;
    alu_write(7, 32'hA);
    alu_write(7, 32'hB);
    #1 chk("hz_both_pending", hazard1, 1);
`ifdef WB_FORWARD_EN
    chk("fwd_youngest", fwd_data1, 32'hB);
`endif
    step();
    chk("hz_last_in_wb", hazard1, 1);
    step();
    chk("hz_cleared", hazard1, 0);

    // async reset mid-cycle with writes in flight
    alu_write(1, 32'h1);
    alu_write(2, 32'h2);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("arst_wb_we", wb_we, 0);
    chk("arst_pending", pending_count, 0);
    step();
    rst = 1'b0;
    repeat (4) step();
    chk("arst_no_write", wb_we, 0);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      if (!a_hold && $urandom_range(0, 2) != 0) begin
        alu_valid = 1; alu_addr = ADDR_W'($urandom_range(0, 7)); alu_data = $urandom; a_hold = 1;
      end
      if (!m_hold && $urandom_range(0, 2) == 0) begin
        mem_valid = 1; mem_addr = ADDR_W'($urandom_range(0, 7)); mem_data = $urandom; m_hold = 1;
      end
      rd_addr1 = ADDR_W'($urandom_range(0, 7));
      rd_addr2 = ADDR_W'($urandom_range(0, 7));
      step();
      if (last_alu_acc) begin a_hold = 0; alu_valid = 0; end
      if (last_mem_acc) begin m_hold = 0; mem_valid = 0; end
    end
    alu_valid = 0; mem_valid = 0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
